// File: rtl/bram_sample_recorder_if.sv
// BRAM port bundle shared by the recorder and the PS-side BRAM.
// The master drives address, data, enable, reset and write enables. The slave returns read data.
interface bram_sample_recorder_if;
  logic [31:0] BRAM_addr;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;

  modport master (
    output BRAM_addr,
    output BRAM_din,
    output BRAM_en,
    output BRAM_rst,
    output BRAM_we,
    input  BRAM_dout
  );

  modport slave (
    input  BRAM_addr,
    input  BRAM_din,
    input  BRAM_en,
    input  BRAM_rst,
    input  BRAM_we,
    output BRAM_dout
  );
endinterface

// File: rtl/bram_sample_recorder.sv
// Records a 16-bit sample stream into BRAM, one sample per 32-bit word, starting at byte address 0.
// Define BRAM_RECORDER_LOOP_EN for circular capture, where only stop ends a recording.
module bram_sample_recorder #(
  parameter int NUM_WORDS = 256
) (
  input  logic                          BRAM_clk,
  input  logic                          rst,
  bram_sample_recorder_if.master        bram,
  input  logic                          start,
  input  logic                          stop,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   words_written,
  output logic                          wrapped
);

  typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [15:0] MAX_CNT  = 16'(NUM_WORDS);

  state_t      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        en_q, en_d;
  logic [3:0]  we_q, we_d;
  logic        bramRst_q;
  logic        xfer;
  logic        unusedDout;
`ifdef BRAM_RECORDER_LOOP_EN
  logic        wrapped_q, wrapped_d;
`endif

  assign xfer = sample_valid && (state_q == RECORD);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    en_d    = 1'b0;
    we_d    = 4'h0;
`ifdef BRAM_RECORDER_LOOP_EN
    wrapped_d = wrapped_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RECORD;
          index_d = 16'd0;
          count_d = 16'd0;
`ifdef BRAM_RECORDER_LOOP_EN
          wrapped_d = 1'b0;
`endif
        end
      end
      RECORD: begin
        // The write is registered here and sits on the port for the whole next cycle.
        if (xfer) begin
          addr_d  = {14'd0, index_q, 2'b00};
          din_d   = {16'h0000, sample_in};
          en_d    = 1'b1;
          we_d    = 4'hF;
          index_d = index_q + 16'd1;
          if (count_q != MAX_CNT) begin
            count_d = count_q + 16'd1;
          end
          if (index_q == LAST_IDX) begin
`ifdef BRAM_RECORDER_LOOP_EN
            index_d   = 16'd0;
            wrapped_d = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end
        if (stop) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BRAM_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      index_q   <= 16'd0;
      count_q   <= 16'd0;
      addr_q    <= 32'd0;
      din_q     <= 32'd0;
      en_q      <= 1'b0;
      we_q      <= 4'h0;
      bramRst_q <= 1'b1;
`ifdef BRAM_RECORDER_LOOP_EN
      wrapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      en_q      <= en_d;
      we_q      <= we_d;
      bramRst_q <= 1'b0;
`ifdef BRAM_RECORDER_LOOP_EN
      wrapped_q <= wrapped_d;
`endif
    end
  end

  assign bram.BRAM_addr = addr_q;
  assign bram.BRAM_din  = din_q;
  assign bram.BRAM_en   = en_q;
  assign bram.BRAM_we   = we_q;
  assign bram.BRAM_rst  = bramRst_q;
  assign unusedDout     = ^bram.BRAM_dout;

  assign sample_ready  = (state_q == RECORD);
  assign busy          = (state_q == RECORD);
  assign done          = (state_q == DONE);
  assign words_written = count_q;
`ifdef BRAM_RECORDER_LOOP_EN
  assign wrapped = wrapped_q;
`else
  assign wrapped = 1'b0;
`endif

endmodule

// File: tb/tb_bram_sample_recorder.sv
// Directed bench for bram_sample_recorder: reset, streaming, full buffer, stop, reset mid-write.
// Also covers the loop build when BRAM_RECORDER_LOOP_EN is defined.
module tb_bram_sample_recorder;

`ifdef BRAM_RECORDER_LOOP_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 8;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] sampleIn;
  logic        sampleValid;
  logic        sampleReady;
  logic        busy;
  logic        done;
  logic [15:0] wordsWritten;
  logic        wrapped;

  int testsRun;
  int testsFailed;

  logic [31:0] logAddr[$];
  logic [31:0] logData[$];

  bram_sample_recorder_if bramBus ();

  assign bramBus.BRAM_dout = 32'd0;

  bram_sample_recorder #(.NUM_WORDS(DEPTH)) dut (
    .BRAM_clk      (clk),
    .rst           (rst),
    .bram          (bramBus.master),
    .start         (start),
    .stop          (stop),
    .sample_in     (sampleIn),
    .sample_valid  (sampleValid),
    .sample_ready  (sampleReady),
    .busy          (busy),
    .done          (done),
    .words_written (wordsWritten),
    .wrapped       (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each write cycle spans exactly one negedge, so logging there sees every write once.
  always @(negedge clk) begin
    if (bramBus.BRAM_en && bramBus.BRAM_we == 4'hF) begin
      logAddr.push_back(bramBus.BRAM_addr);
      logData.push_back(bramBus.BRAM_din);
    end
  end

  task automatic applyStimulus(input logic s, input logic p, input logic v, input logic [15:0] d);
    start       = s;
    stop        = p;
    sampleValid = v;
    sampleIn    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  initial begin
    logic [31:0] expAddr[6];
    logic [31:0] expData[4];
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    sampleValid = 1'b0;
    sampleIn    = 16'h0000;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_bram_rst", 32'(bramBus.BRAM_rst), 32'd1);
    checkOutput("rst_addr", bramBus.BRAM_addr, 32'd0);
    checkOutput("rst_din", bramBus.BRAM_din, 32'd0);
    checkOutput("rst_en", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("rst_we", 32'(bramBus.BRAM_we), 32'd0);
    checkOutput("rst_ready", 32'(sampleReady), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_words", 32'(wordsWritten), 32'd0);
    checkOutput("rst_wrapped", 32'(wrapped), 32'd0);

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("bram_rst_release", 32'(bramBus.BRAM_rst), 32'd0);

    // Valid in IDLE is dropped
    clearLog();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5A5A);
    checkOutput("idle_valid_en", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("idle_valid_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("idle_valid_nolog", 32'(logAddr.size()), 32'd0);

    // start and stop together in IDLE: start wins
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("startstop_busy", 32'(busy), 32'd1);
    checkOutput("startstop_ready", 32'(sampleReady), 32'd1);
    checkOutput("startstop_done", 32'(done), 32'd0);

    // Four back-to-back samples
    clearLog();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001);
    checkOutput("s1_en", 32'(bramBus.BRAM_en), 32'd1);
    checkOutput("s1_we", 32'(bramBus.BRAM_we), 32'hF);
    checkOutput("s1_addr", bramBus.BRAM_addr, 32'h0);
    checkOutput("s1_din", bramBus.BRAM_din, 32'h00000001);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("s2_addr", bramBus.BRAM_addr, 32'h4);
    checkOutput("s2_din", bramBus.BRAM_din, 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000);
    checkOutput("s3_en", 32'(bramBus.BRAM_en), 32'd1);
    checkOutput("s3_din", bramBus.BRAM_din, 32'h00008000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7FFF);
    checkOutput("s4_addr", bramBus.BRAM_addr, 32'hC);
    checkOutput("s4_din", bramBus.BRAM_din, 32'h00007FFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("gap_en", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("gap_we", 32'(bramBus.BRAM_we), 32'd0);
    checkOutput("gap_addr_hold", bramBus.BRAM_addr, 32'hC);
    checkOutput("four_words", 32'(wordsWritten), 32'd4);
    checkOutput("four_log_size", 32'(logAddr.size()), 32'd4);
    expData = '{32'h00000001, 32'h0000FFFF, 32'h00008000, 32'h00007FFF};
    for (int i = 0; i < 4; i++) begin
      if (i < logAddr.size()) begin
        checkOutput($sformatf("four_log_addr%0d", i), logAddr[i], 32'(4 * i));
        checkOutput($sformatf("four_log_data%0d", i), logData[i], expData[i]);
      end
    end

    // stop with no transfer
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stop_done", 32'(done), 32'd1);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_ready", 32'(sampleReady), 32'd0);
    checkOutput("stop_words_hold", 32'(wordsWritten), 32'd4);
    checkOutput("stop_no_write", 32'(bramBus.BRAM_en), 32'd0);

`ifndef BRAM_RECORDER_LOOP_EN
    // Full buffer with continuous valid
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("full_restart_busy", 32'(busy), 32'd1);
    checkOutput("full_restart_words", 32'(wordsWritten), 32'd0);
    clearLog();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i));
      checkOutput($sformatf("full_done_s%0d", i + 1), 32'(done), (i == 7) ? 32'd1 : 32'd0);
    end
    checkOutput("full_last_addr", bramBus.BRAM_addr, 32'h1C);
    checkOutput("full_words", 32'(wordsWritten), 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0099);
    checkOutput("full_9th_no_write", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("full_words_sat", 32'(wordsWritten), 32'd8);
    checkOutput("full_log_size", 32'(logAddr.size()), 32'd8);
    if (logAddr.size() == 8) begin
      checkOutput("full_log_last_addr", logAddr[7], 32'h1C);
      checkOutput("full_log_last_data", logData[7], 32'h00000017);
    end
`else
    // Circular capture with NUM_WORDS=4
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("loop_restart_wrapped", 32'(wrapped), 32'd0);
    clearLog();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020 + 16'(i));
      if (i == 2) checkOutput("loop_wrapped_s3", 32'(wrapped), 32'd0);
      if (i == 4) checkOutput("loop_wrapped_s5", 32'(wrapped), 32'd1);
      checkOutput($sformatf("loop_busy_s%0d", i + 1), 32'(busy), 32'd1);
    end
    checkOutput("loop_words_sat", 32'(wordsWritten), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("loop_log_size", 32'(logAddr.size()), 32'd6);
    expAddr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    for (int i = 0; i < 6; i++) begin
      if (i < logAddr.size()) begin
        checkOutput($sformatf("loop_log_addr%0d", i), logAddr[i], expAddr[i]);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("loop_stop_done", 32'(done), 32'd1);
`endif

    // Gapped valid, stop together with the third sample
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    clearLog();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hAAAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    checkOutput("gapped_done", 32'(done), 32'd1);
    checkOutput("gapped_last_en", 32'(bramBus.BRAM_en), 32'd1);
    checkOutput("gapped_last_addr", bramBus.BRAM_addr, 32'h8);
    checkOutput("gapped_last_din", bramBus.BRAM_din, 32'h00001234);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4321);
    checkOutput("gapped_after_en", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("gapped_words", 32'(wordsWritten), 32'd3);
    checkOutput("gapped_log_size", 32'(logAddr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < logAddr.size()) begin
        checkOutput($sformatf("gapped_log_addr%0d", i), logAddr[i], 32'(4 * i));
      end
    end

    // Reset during a write cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100 + 16'(i));
    end
    checkOutput("midrst_write_en", 32'(bramBus.BRAM_en), 32'd1);
`ifdef BRAM_RECORDER_LOOP_EN
    checkOutput("midrst_write_addr", bramBus.BRAM_addr, 32'h0);
`else
    checkOutput("midrst_write_addr", bramBus.BRAM_addr, 32'h10);
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0DEF);
    checkOutput("midrst_en", 32'(bramBus.BRAM_en), 32'd0);
    checkOutput("midrst_we", 32'(bramBus.BRAM_we), 32'd0);
    checkOutput("midrst_bram_rst", 32'(bramBus.BRAM_rst), 32'd1);
    checkOutput("midrst_addr", bramBus.BRAM_addr, 32'd0);
    checkOutput("midrst_din", bramBus.BRAM_din, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ready", 32'(sampleReady), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_words", 32'(wordsWritten), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0BEE);
    checkOutput("postrst_en", 32'(bramBus.BRAM_en), 32'd1);
    checkOutput("postrst_addr", bramBus.BRAM_addr, 32'h0);
    checkOutput("postrst_din", bramBus.BRAM_din, 32'h00000BEE);
    checkOutput("postrst_words", 32'(wordsWritten), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bram_sample_recorder.md
# bram_sample_recorder

Capture engine that writes a stream of 16-bit audio samples into the PS-shared BRAM, one sample per 32-bit word, starting at byte address 0. It is the writer counterpart to the BRAM-to-sample-buffer loader: it sits on the same BRAM port interface, and its output feeds the loader on the next refresh. Recording is armed by `start` and ends on `stop` or when the buffer fills.

## Interface
Parameters:
- `NUM_WORDS`, 256: buffer depth in 32-bit words; legal range 2..65535.

Ports:
- `BRAM_clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `BRAM_addr`  out  32  byte address; always `4*index`.
- `BRAM_din`  out  32  `{16'h0000, sample}`.
- `BRAM_dout`  in  32  unused; no reads are issued.
- `BRAM_en`  out  1  BRAM enable.
- `BRAM_rst`  out  1  BRAM reset.
- `BRAM_we`  out  4  byte write enables; `4'hF` on write cycles, `4'h0` otherwise.
- `start`  in  1  level-sampled; begins a recording from address 0.
- `stop`  in  1  level-sampled; ends the recording.
- `sample_in`  in  16  signed sample (shortint).
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  high in RECORD only; a sample transfers on `sample_valid & sample_ready`.
- `busy`  out  1  FSM is in RECORD.
- `done`  out  1  FSM is in DONE.
- `words_written`  out  16  samples committed in the current or last recording.
- `wrapped`  out  1  sticky; the index has wrapped (loop mode only).

## Operation
- FSM states are IDLE, RECORD and DONE.
- IDLE:
  - `BRAM_en`=0, `BRAM_we`=0.
  - `start` moves to RECORD and clears `index`, `words_written` and `wrapped`.
  - `stop` is ignored. If `start` and `stop` are high together, `start` wins.
- RECORD:
  - `sample_ready`=1.
  - Each transfer registers a write: `BRAM_addr`=`4*index`, `BRAM_din`=`{16'h0, sample_in}`, `BRAM_en`=1, `BRAM_we`=`4'hF` for exactly one cycle. Then `index` and `words_written` increment.
  - With no transfer, `BRAM_en`=0 and `BRAM_we`=0; `BRAM_addr` holds.
  - Throughput is one sample per cycle, sustained.
- Full buffer: a transfer with `index`=`NUM_WORDS-1` moves to DONE at that same edge. That write is still issued in the following cycle.
- `stop` in RECORD moves to DONE.
  - A transfer in the same cycle as `stop` is accepted and written.
  - `stop` with no transfer leaves no write outstanding.
- DONE:
  - `done`=1; `words_written` holds; `sample_ready`=0.
  - `start` re-enters RECORD with counters cleared, so the recording restarts at address 0.
- `sample_valid` outside RECORD is dropped silently.
- `start` in RECORD is ignored.
- `words_written` never exceeds `NUM_WORDS`; it saturates there.

## Timing
- Reset values (asserted while `rst`=1):
  - `BRAM_rst`=1.
  - `BRAM_addr`=0, `BRAM_din`=0, `BRAM_en`=0, `BRAM_we`=0.
  - `sample_ready`=0, `busy`=0, `done`=0, `words_written`=0, `wrapped`=0.
  - FSM in IDLE.
- `BRAM_rst` drops to 0 on the first edge with `rst`=0.
- Reset mid-recording:
  - A write issued at the reset edge is cancelled: `BRAM_en`/`BRAM_we` are 0 in the next cycle.
  - The BRAM contents already written are left untouched.
- Write latency: a transfer at edge N puts write signals on the port for cycle N..N+1. The BRAM captures them at edge N+1.
- FSM transitions:
  - `start` sampled at edge N gives `busy`=1 and `sample_ready`=1 from N.
  - `done` is 1 from the edge that leaves RECORD.
- All outputs are registered; there is no combinational input-to-output path except `sample_ready`, which is a decode of the registered state.

## Configuration
- Macro: `BRAM_RECORDER_LOOP_EN`.
- Defined (circular capture):
  - On a transfer at `index`=`NUM_WORDS-1`, `index` wraps to 0, the FSM stays in RECORD, and `wrapped` sets.
  - `words_written` saturates at `NUM_WORDS`.
  - Only `stop` reaches DONE.
- Undefined:
  - Behaviour is as in the Operation section: a full buffer ends the recording.
  - `wrapped` is tied to 0.

## Test plan
- Reset, then `start` pulse, then 4 back-to-back samples 0x0001, 0xFFFF, 0x8000, 0x7FFF:
  - Four consecutive write cycles at addresses 0x0, 0x4, 0x8, 0xC.
  - `BRAM_din` = 0x00000001, 0x0000FFFF, 0x00008000, 0x00007FFF.
  - `words_written`=4.
- `NUM_WORDS`=8, continuous valid:
  - Exactly 8 writes, last at 0x1C.
  - `done`=1 on the edge accepting sample 8; the 9th valid sample is not written.
- Gapped valid (1 valid in 3 cycles), then `stop` together with the 3rd sample:
  - 3 writes at 0x0/0x4/0x8; DONE; `words_written`=3.
- Assert `rst` during a write cycle after 5 samples:
  - `BRAM_en`=0 and `BRAM_we`=0 the next cycle; all outputs at reset values.
  - A new `start` writes from 0x0.
- `BRAM_RECORDER_LOOP_EN`, `NUM_WORDS`=4, 6 samples:
  - Writes at 0x0, 0x4, 0x8, 0xC, 0x0, 0x4.
  - `wrapped`=1 after the 5th sample; `words_written`=4; `busy` stays 1 until `stop`.
- `start` and `stop` in the same cycle in IDLE:
  - Enters RECORD; `sample_valid` outside RECORD produces no write.
